// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to a 1-cycle synchronous imem,
// buffers returned words and hands {instr, pc} to decode over a valid/ready handshake.
module instr_fetch_unit #(
  parameter int unsigned              ADDR_W   = 10,
  parameter int unsigned              INSTR_W  = 16,
  parameter logic [ADDR_W-1:0]        RESET_PC = '0,
  parameter int unsigned              DEPTH    = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  output logic [ADDR_W-1:0]  addr_instr,
  output logic               imem_re,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               fetch_en,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               dec_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  pc_out
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W + 1)'(DEPTH);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  entry_t            fifo_q [DEPTH];

  logic              pop;
  logic              push;
  logic              issue;
  logic [CNT_W:0]    occupancy;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign instr_valid = (count_q != '0);
  assign instr_out   = fifo_q[rd_ptr_q].instr;
  assign pc_out      = fifo_q[rd_ptr_q].pc;

  // The in-flight request already owns a buffer slot, so it counts toward occupancy.
  assign pop       = instr_valid & dec_ready & ~br_taken;
  assign push      = inflight_q & ~br_taken;
  assign occupancy = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(pop);
  assign issue     = (fetch_en & (occupancy < DEPTH_V)) | br_taken;

  assign imem_re    = issue;
  assign addr_instr = br_taken ? br_target : pc_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = 1'b0;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;

    if (br_taken) begin
      pc_d       = br_target + ADDR_W'(1);
      req_pc_d   = br_target;
      inflight_d = 1'b1;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else if (issue) begin
      pc_d       = pc_q + ADDR_W'(1);
      req_pc_d   = pc_q;
      inflight_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      // NOTE: the buffer is only DEPTH entries, so it is reset to give instr_out/pc_out
      // a defined zero after reset rather than stale contents.
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      if (push) fifo_q[wr_ptr_q] <= '{instr: instr_in, pc: req_pc_q};
    end
  end

endmodule
